// File: rtl/ddr_pim_sequencer.sv
// Upstream line-request sequencer for the DDR controller PIM0 port: one 4-word transaction at a time,
// write data streamed into the PIM write FIFO, read data popped into a credit-checked response buffer.
module ddr_pim_sequencer #(
   parameter int BURST_WORDS = 4,
   parameter int RSP_DEPTH   = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rnw,
   input  logic [31:0] req_addr,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  logic [63:0] wd_data,
   input  logic [7:0]  wd_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic [31:0] pim_addr,
   output logic        pim_addr_req,
   input  logic        pim_addr_ack,
   output logic        pim_rnw,
   output logic [3:0]  pim_size,
   output logic        pim_rdmodwr,
   output logic [63:0] pim_wr_data,
   output logic [7:0]  pim_wr_be,
   output logic        pim_wr_push,
   input  logic        pim_wr_almost_full,
   output logic        pim_wr_flush,
   output logic        pim_rd_flush,
   input  logic [63:0] pim_rd_data,
   output logic        pim_rd_pop,
   input  logic        pim_rd_empty,
   input  logic [1:0]  pim_rd_latency,
   input  logic        pim_init_done
);

   localparam int CW = $clog2(BURST_WORDS + 1);
   localparam int OW = $clog2(RSP_DEPTH + 1);
   localparam int PW = $clog2(RSP_DEPTH);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_WR_PUSH, S_WR_ADDR, S_RD_ADDR, S_RD_DATA
   } state_t;

   state_t        state_q;
   logic          flushed_q, flush_q;
   logic [31:0]   addr_q;
   logic          rnw_q, addr_req_q, rdmodwr_q, partial_q;
   logic [CW-1:0] word_cnt_q, pop_cnt_q, recv_cnt_q;
   logic [1:0]    lat_q;
   logic [1:0]    sr_q;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [OW-1:0] occ_q, occ_d;
   logic [63:0]   mem_q [RSP_DEPTH];

   logic          req_acc, wd_xfer, rsp_pop, cap, credit_ok;
   logic [OW:0]   committed;
   logic [1:0]    lat_in;
   logic          addr_lo_unused;

   assign addr_lo_unused = ^req_addr[4:0];

   assign req_ready   = (state_q == S_IDLE) && (occ_q == '0);
   assign req_acc     = req_valid && req_ready;
   assign wd_ready    = (state_q == S_WR_PUSH) && !pim_wr_almost_full;
   assign wd_xfer     = wd_valid && wd_ready;
   assign pim_wr_push = wd_xfer;
   assign pim_wr_data = wd_data;
   assign pim_wr_be   = wd_be;

   // Words already popped but not yet captured still hold a buffer slot.
   assign committed  = {1'b0, occ_q} + (OW+1)'(pop_cnt_q - recv_cnt_q);
   assign credit_ok  = committed < (OW+1)'(RSP_DEPTH);
   assign pim_rd_pop = (state_q == S_RD_DATA) && !pim_rd_empty &&
                       (pop_cnt_q < CW'(BURST_WORDS)) && credit_ok;
   assign lat_in     = (pim_rd_latency == 2'd3) ? 2'd2 : pim_rd_latency;

   always_comb begin
      cap = 1'b0;
      if (state_q == S_RD_DATA) begin
         case (lat_q)
            2'd0:    cap = pim_rd_pop;
            2'd1:    cap = sr_q[0];
            default: cap = sr_q[1];
         endcase
      end
   end

   assign rsp_valid = (occ_q != '0);
   assign rsp_data  = mem_q[rptr_q];
   assign rsp_pop   = rsp_valid && rsp_ready;

   always_comb begin
      occ_d = occ_q;
      if (cap && !rsp_pop)
         occ_d = occ_q + OW'(1);
      else if (!cap && rsp_pop)
         occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge CLK) begin
      if (cap)
         mem_q[wptr_q] <= pim_rd_data;
   end

   assign pim_addr     = addr_q;
   assign pim_addr_req = addr_req_q;
   assign pim_rnw      = rnw_q;
   assign pim_rdmodwr  = rdmodwr_q;
   assign pim_size     = 4'd1;
   assign pim_wr_flush = flush_q;
   assign pim_rd_flush = flush_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= S_INIT;
         flushed_q  <= 1'b0;
         flush_q    <= 1'b0;
         addr_q     <= '0;
         rnw_q      <= 1'b0;
         addr_req_q <= 1'b0;
         rdmodwr_q  <= 1'b0;
         partial_q  <= 1'b0;
         word_cnt_q <= '0;
         pop_cnt_q  <= '0;
         recv_cnt_q <= '0;
         lat_q      <= '0;
         sr_q       <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         occ_q      <= '0;
      end else begin
         sr_q    <= {sr_q[0], pim_rd_pop};
         occ_q   <= occ_d;
         flush_q <= 1'b0;
         if (cap)
            wptr_q <= (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
         if (rsp_pop)
            rptr_q <= (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);

         case (state_q)
            S_INIT: begin
               if (!flushed_q) begin
                  flush_q   <= 1'b1;
                  flushed_q <= 1'b1;
               end else if (pim_init_done) begin
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (req_acc) begin
                  addr_q     <= {req_addr[31:5], 5'b0};
                  rnw_q      <= req_rnw;
                  word_cnt_q <= '0;
                  partial_q  <= 1'b0;
                  if (req_rnw) begin
                     state_q    <= S_RD_ADDR;
                     addr_req_q <= 1'b1;
                  end else begin
                     state_q <= S_WR_PUSH;
                  end
               end
            end
            S_WR_PUSH: begin
               if (wd_xfer) begin
                  word_cnt_q <= word_cnt_q + CW'(1);
                  if (wd_be != 8'hFF)
                     partial_q <= 1'b1;
                  if (word_cnt_q == CW'(BURST_WORDS - 1)) begin
                     state_q    <= S_WR_ADDR;
                     addr_req_q <= 1'b1;
                     rdmodwr_q  <= partial_q || (wd_be != 8'hFF);
                  end
               end
            end
            S_WR_ADDR: begin
               if (pim_addr_ack) begin
                  state_q    <= S_IDLE;
                  addr_req_q <= 1'b0;
                  rdmodwr_q  <= 1'b0;
               end
            end
            S_RD_ADDR: begin
               if (pim_addr_ack) begin
                  state_q    <= S_RD_DATA;
                  addr_req_q <= 1'b0;
                  pop_cnt_q  <= '0;
                  recv_cnt_q <= '0;
                  lat_q      <= lat_in;
               end
            end
            S_RD_DATA: begin
               if (pim_rd_pop)
                  pop_cnt_q <= pop_cnt_q + CW'(1);
               if (cap) begin
                  recv_cnt_q <= recv_cnt_q + CW'(1);
                  if (recv_cnt_q == CW'(BURST_WORDS - 1))
                     state_q <= S_IDLE;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_pim_sequencer.sv
// Bench for ddr_pim_sequencer: directed and random line transactions against a queue-based PIM model.
module tb_ddr_pim_sequencer;

   logic        CLK, RST_N;
   logic        req_valid, req_ready, req_rnw;
   logic [31:0] req_addr;
   logic        wd_valid, wd_ready;
   logic [63:0] wd_data;
   logic [7:0]  wd_be;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic [31:0] pim_addr;
   logic        pim_addr_req, pim_addr_ack, pim_rnw, pim_rdmodwr;
   logic [3:0]  pim_size;
   logic [63:0] pim_wr_data;
   logic [7:0]  pim_wr_be;
   logic        pim_wr_push, pim_wr_almost_full, pim_wr_flush, pim_rd_flush;
   logic [63:0] pim_rd_data;
   logic        pim_rd_pop, pim_rd_empty;
   logic [1:0]  pim_rd_latency;
   logic        pim_init_done;

   ddr_pim_sequencer #(.BURST_WORDS(4), .RSP_DEPTH(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw), .req_addr(req_addr),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_be(wd_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .pim_addr(pim_addr), .pim_addr_req(pim_addr_req), .pim_addr_ack(pim_addr_ack),
      .pim_rnw(pim_rnw), .pim_size(pim_size), .pim_rdmodwr(pim_rdmodwr),
      .pim_wr_data(pim_wr_data), .pim_wr_be(pim_wr_be), .pim_wr_push(pim_wr_push),
      .pim_wr_almost_full(pim_wr_almost_full),
      .pim_wr_flush(pim_wr_flush), .pim_rd_flush(pim_rd_flush),
      .pim_rd_data(pim_rd_data), .pim_rd_pop(pim_rd_pop), .pim_rd_empty(pim_rd_empty),
      .pim_rd_latency(pim_rd_latency), .pim_init_done(pim_init_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // PIM read FIFO model: word k of the global pop stream appears latency cycles after pop k
   logic [63:0] rd_mem [64];
   logic [63:0] push_dat [$];
   logic [7:0]  push_be  [$];
   logic [63:0] rsp_got  [$];
   int          pops_total = 0;
   int          cyc = 0;
   int          hist [3] = '{0, 0, 0};
   logic        s_req_acc, s_wd_xfer, s_wd_ready, s_pop, s_rsp_valid, s_addr_req;

   task automatic tick();
      @(negedge CLK);
      s_req_acc   = req_valid && req_ready;
      s_wd_xfer   = wd_valid && wd_ready;
      s_wd_ready  = wd_ready;
      s_pop       = pim_rd_pop;
      s_rsp_valid = rsp_valid;
      s_addr_req  = pim_addr_req;
      if (pim_wr_push) begin
         push_dat.push_back(pim_wr_data);
         push_be.push_back(pim_wr_be);
      end
      if (rsp_valid && rsp_ready) rsp_got.push_back(rsp_data);
      if (pim_rd_pop) pops_total++;
      @(posedge CLK);
      #1;
      cyc++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pops_total;
      pim_rd_data = rd_mem[hist[pim_rd_latency] % 64];
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_wd_ready"}, wd_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_addr_req"}, pim_addr_req, 0);
      chk({tag, "_wr_push"}, pim_wr_push, 0);
      chk({tag, "_rd_pop"}, pim_rd_pop, 0);
      chk({tag, "_flushes"}, {pim_wr_flush, pim_rd_flush}, 0);
      chk({tag, "_addr"}, pim_addr, 0);
      chk({tag, "_rnw"}, pim_rnw, 0);
      chk({tag, "_rdmodwr"}, pim_rdmodwr, 0);
   endtask

   task automatic wait_ready();
      int g = 0;
      while (!req_ready && g < 200) begin
         tick();
         g++;
      end
      chk("req_ready_wait", req_ready, 1);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] bes, input int ack_dly,
                           input int af_after, input int af_len, input bit af_rand);
      logic [63:0] w [4];
      bit part = 0;
      bit af_done = 0;
      int n = 0, guard = 0, af_left = 0, hi = 0;
      for (int i = 0; i < 4; i++) begin
         w[i] = {$urandom, $urandom};
         if (bes[8*i +: 8] != 8'hFF) part = 1;
      end
      wait_ready();
      req_valid = 1; req_rnw = 0; req_addr = addr;
      tick();
      chk("wr_accept", s_req_acc, 1);
      req_valid = 0; req_addr = $urandom;
      push_dat.delete(); push_be.delete();
      while (n < 4 && guard < 100) begin
         wd_valid = 1; wd_data = w[n]; wd_be = bes[8*n +: 8];
         if (!af_done && af_len > 0 && n == af_after) begin
            af_left = af_len;
            af_done = 1;
         end
         pim_wr_almost_full = (af_left > 0) || (af_rand && $urandom_range(0, 4) == 0);
         tick();
         guard++;
         if (af_left > 0) begin
            chk("wr_stall_wd_ready", s_wd_ready, 0);
            af_left--;
         end
         if (s_wd_xfer) n++;
      end
      wd_valid = 0; pim_wr_almost_full = 0;
      chk("wr_words_sent", n, 4);
      chk("wr_addr_req_rise", pim_addr_req, 1);
      chk("wr_addr", pim_addr, {addr[31:5], 5'b0});
      chk("wr_rnw", pim_rnw, 0);
      chk("wr_size", pim_size, 4'd1);
      chk("wr_rdmodwr", pim_rdmodwr, part);
      for (int k = 1; k <= ack_dly; k++) begin
         pim_addr_ack = (k == ack_dly);
         tick();
         hi += int'(s_addr_req);
      end
      pim_addr_ack = 0;
      chk("wr_addr_req_cycles", hi, ack_dly);
      chk("wr_addr_req_drop", pim_addr_req, 0);
      chk("wr_back_idle", req_ready, 1);
      chk("wr_push_count", push_dat.size(), 4);
      for (int i = 0; i < 4 && i < push_dat.size(); i++) begin
         chk("wr_push_data", push_dat[i], w[i]);
         chk("wr_push_be", push_be[i], bes[8*i +: 8]);
      end
   endtask

   // mode 0: always ready, never empty; 1: hold rsp_ready low then drain; 2: random ready/empty
   task automatic do_read(input logic [31:0] addr, input int lat, input int ack_dly, input int mode);
      int base, p0, guard = 0, first_pop = -1, first_vld = -1, c;
      wait_ready();
      req_valid = 1; req_rnw = 1; req_addr = addr;
      tick();
      chk("rd_accept", s_req_acc, 1);
      req_valid = 0; req_addr = $urandom;
      chk("rd_addr_req_rise", pim_addr_req, 1);
      chk("rd_addr", pim_addr, {addr[31:5], 5'b0});
      chk("rd_rnw", pim_rnw, 1);
      chk("rd_rdmodwr", pim_rdmodwr, 0);
      pim_rd_latency = 2'(lat);
      rsp_got.delete();
      for (int k = 1; k <= ack_dly; k++) begin
         pim_addr_ack = (k == ack_dly);
         tick();
      end
      pim_addr_ack = 0;
      chk("rd_addr_req_drop", pim_addr_req, 0);
      base = pops_total;
      p0 = pops_total;
      while (rsp_got.size() < 4 && guard < 300) begin
         case (mode)
            0: begin rsp_ready = 1; pim_rd_empty = 0; end
            1: begin
               if (guard == 20) begin
                  chk("rd_hold_pops", pops_total - p0, 4);
                  chk("rd_hold_valid", rsp_valid, 1);
                  chk("rd_hold_no_accept", req_ready, 0);
               end
               rsp_ready = (guard >= 20); pim_rd_empty = 0;
            end
            default: begin
               rsp_ready = 1'($urandom_range(0, 1));
               pim_rd_empty = ($urandom_range(0, 3) == 0);
            end
         endcase
         c = cyc;
         tick();
         guard++;
         if (s_pop && first_pop < 0) first_pop = c;
         if (s_rsp_valid && first_vld < 0) first_vld = c;
      end
      rsp_ready = 1; pim_rd_empty = 0;
      chk("rd_words", rsp_got.size(), 4);
      chk("rd_pops", pops_total - p0, 4);
      chk("rd_first_valid_delay", first_vld - first_pop, lat + 1);
      for (int i = 0; i < 4 && i < rsp_got.size(); i++)
         chk("rd_data", rsp_got[i], rd_mem[(base + i) % 64]);
      chk("rd_valid_clear", rsp_valid, 0);
      chk("rd_back_idle", req_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int p0, g;
      for (int i = 0; i < 64; i++) rd_mem[i] = {$urandom, $urandom};
      RST_N = 0; req_valid = 0; req_rnw = 0; req_addr = 0;
      wd_valid = 0; wd_data = 0; wd_be = 0; rsp_ready = 1;
      pim_addr_ack = 0; pim_wr_almost_full = 0; pim_rd_data = 0;
      pim_rd_empty = 0; pim_rd_latency = 0; pim_init_done = 0;
      repeat (3) tick();
      chk_reset("rst");
      chk("rst_size", pim_size, 4'd1);
      RST_N = 1;
      tick();
      chk("flush_pulse", {pim_wr_flush, pim_rd_flush}, 2'b11);
      chk("init_req_ready", req_ready, 0);
      tick();
      chk("flush_end", {pim_wr_flush, pim_rd_flush}, 2'b00);
      repeat (3) tick();
      chk("init_wait_req_ready", req_ready, 0);
      pim_init_done = 1;
      tick();
      chk("init_done_req_ready", req_ready, 1);

      do_write(32'h1234_5678, 32'hFFFF_FFFF, 3, 0, 0, 0);
      do_write(32'hA000_0040, {8'hFF, 8'h0F, 8'hFF, 8'hFF}, 2, 0, 0, 0);
      do_write(32'h0000_1000, 32'hFFFF_FFFF, 1, 1, 5, 0);
      do_read(32'h8765_4321, 1, 2, 0);
      do_read(32'h0000_0020, 2, 1, 1);
      do_read(32'h0BAD_F00D, 0, 1, 0);

      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_read($urandom, $urandom_range(0, 2), $urandom_range(1, 4), 2);
         end else begin
            logic [31:0] bes;
            for (int b = 0; b < 4; b++)
               bes[8*b +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            do_write($urandom, bes, $urandom_range(1, 4), 0, 0, 1);
         end
      end

      // Reset in the middle of a read, after two pops
      wait_ready();
      req_valid = 1; req_rnw = 1; req_addr = 32'h4000_0100;
      tick();
      req_valid = 0;
      pim_rd_latency = 2'd1;
      pim_addr_ack = 1;
      tick();
      pim_addr_ack = 0;
      rsp_ready = 0; pim_rd_empty = 0;
      p0 = pops_total; g = 0;
      while (pops_total - p0 < 2 && g < 50) begin
         tick();
         g++;
      end
      chk("mid_rst_two_pops", pops_total - p0, 2);
      RST_N = 0; pim_init_done = 0;
      tick();
      chk_reset("mid_rst");
      RST_N = 1;
      tick();
      chk("mid_rst_flush_pulse", {pim_wr_flush, pim_rd_flush}, 2'b11);
      tick();
      chk("mid_rst_flush_end", {pim_wr_flush, pim_rd_flush}, 2'b00);
      repeat (4) tick();
      chk("mid_rst_hold_req_ready", req_ready, 0);
      pim_init_done = 1;
      rsp_ready = 1;
      tick();
      chk("mid_rst_recover", req_ready, 1);
      do_read(32'h4000_0100, 2, 2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
